// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: access-size encodings,
// controller states and the bus word size.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        DONE
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsu_if.sv
// Data-memory word bus between the load/store initiator (master) and the
// data RAM or memory-mapped responders (slave).
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W/8-1:0]   m_be;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_be, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_be, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable footprint, write-data lane shift and
// split detection for a request, plus load extraction/extension from one or
// two returned beats.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  size_t       i_size,
    input  logic [31:0] i_wdata,
    output logic [7:0]  o_mask8,
    output logic [63:0] o_data64,
    output logic        o_split,
    input  logic [1:0]  i_ld_off,
    input  size_t       i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_base;
    logic [31:0] w_lo;

    // Unshifted byte footprint of the access size.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves the value held (no latch).
        w_base = 8'h00;
        case (i_size)
            SZ_B:    w_base = 8'h01;
            SZ_H:    w_base = 8'h03;
            SZ_W:    w_base = 8'h0F;
            default: w_base = 8'h00;
        endcase
    end

    assign o_mask8  = w_base << i_off;
    assign o_data64 = {32'd0, i_wdata} << {i_off, 3'b000};
    assign o_split  = |o_mask8[7:4];

    // Bring the addressed byte down to lane 0 across the two-beat window.
    assign w_lo = 32'({i_rdata1, i_rdata0} >> {i_ld_off, 3'b000});

    // Keep only the accessed bytes and sign/zero-extend them.
    always_comb begin
        o_ld_data = 32'd0;
        case (i_ld_size)
            SZ_B:    o_ld_data = i_ld_unsigned ? {24'd0, w_lo[7:0]}
                                               : {{24{w_lo[7]}}, w_lo[7:0]};
            SZ_H:    o_ld_data = i_ld_unsigned ? {16'd0, w_lo[15:0]}
                                               : {{16{w_lo[15]}}, w_lo[15:0]};
            SZ_W:    o_ld_data = w_lo;
            default: o_ld_data = 32'd0;
        endcase
    end
endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: accepts one byte/half/word request from execute,
// issues one or two aligned word beats and returns extended load data.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests error
// out without touching the bus instead of being split.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    lsu_if.master             bus
);
    state_t              r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_m_valid;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [3:0]          r_m_be;
    logic [DATA_W-1:0]   r_m_wdata;
    logic                r_store;
    logic                r_split;
    logic [1:0]          r_off;
    size_t               r_size;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_addr_hi;
    logic [3:0]          r_be_hi;
    logic [DATA_W-1:0]   r_wdata_hi;
    logic [DATA_W-1:0]   r_rdata0;

    size_t               w_size;
    logic [ADDR_W-1:0]   w_word;
    logic [7:0]          w_mask8;
    logic [63:0]         w_data64;
    logic                w_split;
    logic [DATA_W-1:0]   w_ld_rd0;
    logic [DATA_W-1:0]   w_ld_rd1;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_trap;
    logic                w_accept;

    assign w_size   = size_t'(req_size);
    assign w_word   = {req_addr[ADDR_W-1:2], 2'b00};
    assign w_accept = req_valid && r_req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                        ((w_size == SZ_H) && req_addr[0]);
    assign w_trap     = (w_size == SZ_RSV) || w_misalign;
`else
    assign w_trap     = (w_size == SZ_RSV);
`endif

    // The second beat's data is live on the bus in WAIT1; otherwise the
    // current beat is the only one and the upper word reads as zero.
    assign w_ld_rd0 = (r_state == WAIT1) ? r_rdata0 : bus.m_rdata;
    assign w_ld_rd1 = (r_state == WAIT1) ? bus.m_rdata : '0;

    lsu_align u_align (
        .i_off         (req_addr[1:0]),
        .i_size        (w_size),
        .i_wdata       (req_wdata),
        .o_mask8       (w_mask8),
        .o_data64      (w_data64),
        .o_split       (w_split),
        .i_ld_off      (r_off),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_rdata0      (w_ld_rd0),
        .i_rdata1      (w_ld_rd1),
        .o_ld_data     (w_ld_data)
    );

    // Transaction sequencer with registered bus and response outputs.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use <= so every branch reads pre-edge values.
        if (RST) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_m_valid    <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_be       <= 4'h0;
            r_m_wdata    <= '0;
            r_store      <= 1'b0;
            r_split      <= 1'b0;
            r_off        <= 2'b00;
            r_size       <= SZ_B;
            r_unsigned   <= 1'b0;
            r_addr_hi    <= '0;
            r_be_hi      <= 4'h0;
            r_wdata_hi   <= '0;
            r_rdata0     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_store     <= req_store;
                        r_size      <= w_size;
                        r_unsigned  <= req_unsigned;
                        r_off       <= req_addr[1:0];
                        r_split     <= w_split;
                        r_addr_hi   <= w_word + ADDR_W'(WORD_BYTES);
                        r_be_hi     <= w_mask8[7:4];
                        r_wdata_hi  <= w_data64[63:32];
                        r_rdata0    <= '0;
                        if (w_trap) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state   <= ISSUE0;
                            r_m_valid <= 1'b1;
                            r_m_we    <= req_store;
                            r_m_addr  <= w_word;
                            r_m_be    <= w_mask8[3:0];
                            r_m_wdata <= w_data64[31:0];
                        end
                    end
                end
                ISSUE0: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        if (!r_store) begin
                            r_state <= WAIT0;
                        end else if (r_split) begin
                            r_state   <= ISSUE1;
                            r_m_valid <= 1'b1;
                            r_m_addr  <= r_addr_hi;
                            r_m_be    <= r_be_hi;
                            r_m_wdata <= r_wdata_hi;
                        end else begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                WAIT0: begin
                    if (bus.m_rvalid) begin
                        if (r_split) begin
                            r_state   <= ISSUE1;
                            r_rdata0  <= bus.m_rdata;
                            r_m_valid <= 1'b1;
                            r_m_addr  <= r_addr_hi;
                            r_m_be    <= r_be_hi;
                        end else begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_ld_data;
                        end
                    end
                end
                ISSUE1: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_store) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (bus.m_rvalid) begin
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_ld_data;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_resp_rdata;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_we      = r_m_we;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_be      = r_m_be;
    assign bus.m_wdata   = r_m_wdata;
endmodule
